seq_detect_param: RTL and testbench
===================================

Name: seq_detect_param

Overview:
- Parametrised serial bit-sequence detector with a runtime-programmable pattern (1..MAX_LEN bits).
- Selectable overlapping or non-overlapping match mode, qualified input sampling, and a saturating match counter.
- Sits on a 1-bit serial data path and flags each completed occurrence of the programmed pattern.
- Reset configuration defaults to pattern "101", overlapping.

Parameters:
- MAX_LEN, 8, maximum pattern length in bits (>=2).
- CW, 8, width of match_count.
- RESET_PATTERN, 'b101, pattern loaded at reset (MAX_LEN bits, LSB-aligned).
- RESET_LEN, 3, pattern length loaded at reset.
- RESET_OVERLAP, 1, overlap mode loaded at reset.
- Derived: LW = $clog2(MAX_LEN+1).

Ports:
- clk  in  1  clock.
- reset  in  1  reset; asynchronous, active-high.
- d  in  1  serial data bit.
- d_valid  in  1  d sampled only when high.
- cfg_load  in  1  single-cycle pulse; latches cfg_pattern, cfg_len and cfg_overlap.
- cfg_pattern  in  MAX_LEN  pattern; bit [len-1] is the first bit received, bit [0] the last.
- cfg_len  in  LW  pattern length.
- cfg_overlap  in  1  1 = overlapping matches, 0 = non-overlapping.
- clr_count  in  1  synchronous clear of match_count.
- match  out  1  one-cycle pulse per detected occurrence.
- armed  out  1  history holds at least len valid bits.
- match_count  out  CW  saturating count of matches.

Behaviour:
- Reset (async):
  - Config registers take RESET_PATTERN / RESET_LEN / RESET_OVERLAP.
  - History = 0, fill = 0, match = 0, armed = 0, match_count = 0.
- Datapath:
  - History shift register hist[MAX_LEN-1:0]. On d_valid: hist <= {hist[MAX_LEN-2:0], d}.
  - fill increments on each d_valid and saturates at MAX_LEN.
  - No d_valid: hist, fill and match_count hold; match = 0.
- Hit: computed on the next-state values. Hit = d_valid && len != 0 && next_fill >= len && next_hist[len-1:0] == pattern[len-1:0].
- Latency: match is registered. It is high in the cycle after the clock edge that sampled the last pattern bit, for exactly one cycle, per hit. Back-to-back hits produce consecutive match cycles.
- Overlap mode: fill is not reset on a hit, so suffix/prefix overlaps match. Example: "101" on 10101 gives 2 hits.
- Non-overlap mode: on a hit, next_fill is forced to 0, so the next match needs len fresh bits. Example: "101" on 10101 gives 1 hit.
- armed = registered (fill >= len && len != 0).
- Config load:
  - On a cfg_load cycle, the new config is latched and hist and fill clear to 0.
  - A d_valid in the same cycle is discarded; match = 0 on the next cycle.
  - match_count is unaffected.
- Length rules:
  - cfg_len = 0: detector disabled; match and armed are never asserted.
  - cfg_len > MAX_LEN: clamped to MAX_LEN at load.
  - Pattern bits above len-1 are ignored.
- match_count:
  - Increments by 1 on each cycle where match is asserted.
  - Saturates at 2^CW-1; no wrap.
  - clr_count has priority over a simultaneous increment; result = 0.
- Reset mid-sequence: all partial history is lost, and the first match again requires len fresh bits after deassertion.

Test Plan:
- Defaults, d_valid=1, d = 1,0,1,0,1 -> match pulses in the cycles after bit 3 and bit 5; match_count = 2; armed = 1 from after bit 3.
- Load pattern=0b101, len=3, overlap=0; stream 1,0,1,0,1,1,0,1 -> matches after bit 3 and bit 8 only; match_count = 2.
- Load pattern=0b1101, len=4, overlap=1; stream 1,1,0,1,1,0,1 with d_valid low for 2 cycles between bits 2 and 3 -> matches after bit 4 and bit 7; no match during the gaps.
- CW=2, overlap=1, pattern "1" (len=1), 5 valid 1s -> match high for 5 consecutive cycles; match_count = 3 (saturated). clr_count asserted together with a match -> count = 0.
- Assert reset after bits 1,0 of "101", release, send 1 -> no match; then send 0,1 -> match; match_count = 1.
- cfg_load with cfg_len=0 -> no match on any stream. cfg_len=15 with MAX_LEN=8 -> behaves as length 8.

Source files
------------

// File: rtl/seq_detect_param.sv
// Serial bit-sequence detector with a runtime-programmable pattern of 1..MAX_LEN bits,
// overlapping or non-overlapping match mode, and a saturating match counter.
module seq_detect_param #(
  parameter int unsigned          MAX_LEN       = 8,
  parameter int unsigned          CW            = 8,
  parameter logic [MAX_LEN-1:0]   RESET_PATTERN = MAX_LEN'('b101),
  parameter int unsigned          RESET_LEN     = 3,
  parameter bit                   RESET_OVERLAP = 1'b1,
  localparam int unsigned         LW            = $clog2(MAX_LEN + 1)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               d,
  input  logic               d_valid,
  input  logic               cfg_load,
  input  logic [MAX_LEN-1:0] cfg_pattern,
  input  logic [LW-1:0]      cfg_len,
  input  logic               cfg_overlap,
  input  logic               clr_count,
  output logic               match,
  output logic               armed,
  output logic [CW-1:0]      match_count
);

  logic [MAX_LEN-1:0] pat_q, pat_d;
  logic [LW-1:0]      len_q, len_d;
  logic               ovl_q, ovl_d;
  logic [MAX_LEN-1:0] hist_q, hist_d;
  logic [LW-1:0]      fill_q, fill_d;
  logic               match_q, armed_q;
  logic [CW-1:0]      count_q;
  logic [MAX_LEN-1:0] mask;
  logic [LW-1:0]      len_eff;
  logic               hit;

  always_comb begin
    len_eff = (cfg_len > LW'(MAX_LEN)) ? LW'(MAX_LEN) : cfg_len;
    pat_d   = pat_q;
    len_d   = len_q;
    ovl_d   = ovl_q;
    hist_d  = hist_q;
    fill_d  = fill_q;
    hit     = 1'b0;
    // Only the low len bits of history and pattern take part in the compare.
    mask    = '0;
    for (int i = 0; i < MAX_LEN; i++) begin
      mask[i] = (LW'(i) < len_q);
    end
    if (cfg_load) begin
      pat_d  = cfg_pattern;
      len_d  = len_eff;
      ovl_d  = cfg_overlap;
      hist_d = '0;
      fill_d = '0;
    end else if (d_valid) begin
      hist_d = {hist_q[MAX_LEN-2:0], d};
      if (fill_q != LW'(MAX_LEN)) begin
        fill_d = fill_q + LW'(1);
      end
      hit = (len_q != '0) && (fill_d >= len_q) && ((hist_d & mask) == (pat_q & mask));
      // Non-overlapping: the next occurrence needs len fresh bits.
      if (hit && !ovl_q) begin
        fill_d = '0;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pat_q   <= RESET_PATTERN;
      len_q   <= LW'(RESET_LEN);
      ovl_q   <= RESET_OVERLAP;
      hist_q  <= '0;
      fill_q  <= '0;
      match_q <= 1'b0;
      armed_q <= 1'b0;
      count_q <= '0;
    end else begin
      pat_q   <= pat_d;
      len_q   <= len_d;
      ovl_q   <= ovl_d;
      hist_q  <= hist_d;
      fill_q  <= fill_d;
      match_q <= hit;
      armed_q <= (len_d != '0) && (fill_d >= len_d);
      if (clr_count) begin
        count_q <= '0;
      end else if (match_q && (count_q != {CW{1'b1}})) begin
        count_q <= count_q + CW'(1);
      end
    end
  end

  assign match       = match_q;
  assign armed       = armed_q;
  assign match_count = count_q;

endmodule

// File: tb/tb_seq_detect_param.sv
// Directed bench for seq_detect_param: default-width instance plus a CW=2 instance
// sharing the same stimulus to exercise counter saturation.
module tb_seq_detect_param;

  localparam int unsigned MAX_LEN = 8;
  localparam int unsigned LW      = $clog2(MAX_LEN + 1);

  logic               clk = 1'b0;
  logic               reset;
  logic               d;
  logic               d_valid;
  logic               cfg_load;
  logic [MAX_LEN-1:0] cfg_pattern;
  logic [LW-1:0]      cfg_len;
  logic               cfg_overlap;
  logic               clr_count;
  logic               match, armed;
  logic [7:0]         match_count;
  logic               match_s, armed_s;
  logic [1:0]         count_s;

  int n_checks = 0;
  int n_fail   = 0;

  seq_detect_param u_dut (
    .clk         (clk),
    .reset       (reset),
    .d           (d),
    .d_valid     (d_valid),
    .cfg_load    (cfg_load),
    .cfg_pattern (cfg_pattern),
    .cfg_len     (cfg_len),
    .cfg_overlap (cfg_overlap),
    .clr_count   (clr_count),
    .match       (match),
    .armed       (armed),
    .match_count (match_count)
  );

  seq_detect_param #(.CW(2)) u_sat (
    .clk         (clk),
    .reset       (reset),
    .d           (d),
    .d_valid     (d_valid),
    .cfg_load    (cfg_load),
    .cfg_pattern (cfg_pattern),
    .cfg_len     (cfg_len),
    .cfg_overlap (cfg_overlap),
    .clr_count   (clr_count),
    .match       (match_s),
    .armed       (armed_s),
    .match_count (count_s)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Bits are given MSB-first: index n-1 is the first bit sent.
  task automatic run_seq(input string tag, input logic [15:0] bits, input logic [15:0] valid,
                         input logic [15:0] expm, input logic [15:0] expa, input int n,
                         input bit chk_a);
    for (int i = n - 1; i >= 0; i--) begin
      d_valid = valid[i];
      d       = bits[i];
      @(posedge clk);
      #1;
      check_eq($sformatf("%s match step%0d", tag, n - i), {31'd0, match}, {31'd0, expm[i]});
      check_eq($sformatf("%s sat match step%0d", tag, n - i), {31'd0, match_s},
               {31'd0, expm[i]});
      if (chk_a) begin
        check_eq($sformatf("%s armed step%0d", tag, n - i), {31'd0, armed}, {31'd0, expa[i]});
      end
    end
    d_valid = 1'b0;
  endtask

  task automatic idle(input string tag);
    d_valid = 1'b0;
    @(posedge clk);
    #1;
    check_eq({tag, " idle match"}, {31'd0, match}, 32'd0);
  endtask

  // A d_valid=1, d=1 beat rides along with every load to show it is discarded.
  task automatic load(input string tag, input logic [MAX_LEN-1:0] pat, input logic [LW-1:0] len,
                      input logic ovl, input logic clr);
    cfg_load    = 1'b1;
    cfg_pattern = pat;
    cfg_len     = len;
    cfg_overlap = ovl;
    clr_count   = clr;
    d_valid     = 1'b1;
    d           = 1'b1;
    @(posedge clk);
    #1;
    cfg_load  = 1'b0;
    clr_count = 1'b0;
    d_valid   = 1'b0;
    check_eq({tag, " load match"}, {31'd0, match}, 32'd0);
    check_eq({tag, " load armed"}, {31'd0, armed}, 32'd0);
  endtask

  task automatic check_counts(input string tag, input int exp_main, input int exp_sat);
    check_eq({tag, " count"}, {24'd0, match_count}, exp_main);
    check_eq({tag, " sat count"}, {30'd0, count_s}, exp_sat);
  endtask

  initial begin
    reset       = 1'b1;
    d           = 1'b0;
    d_valid     = 1'b0;
    cfg_load    = 1'b0;
    cfg_pattern = '0;
    cfg_len     = '0;
    cfg_overlap = 1'b0;
    clr_count   = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_eq("reset match", {31'd0, match}, 32'd0);
    check_eq("reset armed", {31'd0, armed}, 32'd0);
    check_counts("reset", 0, 0);
    reset = 1'b0;

    // Defaults: "101", overlapping
    run_seq("dflt", 16'b10101, 16'b11111, 16'b00101, 16'b00111, 5, 1'b1);
    idle("dflt");
    check_counts("dflt", 2, 2);

    // Non-overlapping "101"
    load("novl", 8'b101, 4'd3, 1'b0, 1'b1);
    run_seq("novl", 16'b10101101, 16'hff, 16'b00100001, 16'b00000110, 8, 1'b1);
    idle("novl");
    check_counts("novl", 2, 2);

    // "1101" overlapping with a two-cycle valid gap; count kept, sat instance saturates
    load("gap", 8'b1101, 4'd4, 1'b1, 1'b0);
    run_seq("gap", 16'b110001101, 16'b110011111, 16'b000001001, 16'd0, 9, 1'b0);
    idle("gap");
    check_counts("gap", 4, 3);

    // len=1 pattern "1": back-to-back matches, saturation, clear priority
    load("len1", 8'b1, 4'd1, 1'b1, 1'b1);
    run_seq("len1", 16'b11111, 16'b11111, 16'b11111, 16'b11111, 5, 1'b1);
    check_counts("len1", 4, 3);
    d_valid   = 1'b1;
    d         = 1'b1;
    clr_count = 1'b1;
    @(posedge clk);
    #1;
    clr_count = 1'b0;
    d_valid   = 1'b0;
    check_eq("clr match", {31'd0, match}, 32'd1);
    check_counts("clr", 0, 0);
    idle("clr");
    check_counts("post clr", 1, 1);

    // Reset mid-sequence drops partial history
    load("rst", 8'b101, 4'd3, 1'b1, 1'b0);
    check_counts("rst load", 1, 1);
    run_seq("rst pre", 16'b10, 16'b11, 16'b00, 16'd0, 2, 1'b0);
    reset = 1'b1;
    #2;
    check_eq("rst async match", {31'd0, match}, 32'd0);
    check_counts("rst async", 0, 0);
    reset = 1'b0;
    run_seq("rst post", 16'b101, 16'b111, 16'b001, 16'b001, 3, 1'b1);
    idle("rst");
    check_counts("rst", 1, 1);

    // len=0 disables the detector
    load("len0", 8'b0, 4'd0, 1'b1, 1'b1);
    run_seq("len0", 16'b11110000, 16'hff, 16'd0, 16'd0, 8, 1'b1);
    idle("len0");
    check_counts("len0", 0, 0);

    // len=15 clamps to 8: a 7-bit-length match at step 7 must not fire
    load("clamp", 8'b10110011, 4'd15, 1'b1, 1'b0);
    run_seq("clamp", 16'b011001110110011, 16'h7fff, 16'b000000000000001,
            16'b000000011111111, 15, 1'b1);
    idle("clamp");
    check_counts("clamp", 1, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
